// File: rtl/wb_stage_if.sv
// Memory-to-writeback handshake: valid/allowin plus payload bus.
// master = memory stage (drives valid/bus), slave = wb_stage.
interface wb_stage_if #(
  parameter int MS2WS_BUS_LEN = 152
);
  logic                     ms2ws_valid;
  logic                     ws_allowin;
  logic [MS2WS_BUS_LEN-1:0] ms2ws_bus;

  modport master (
    output ms2ws_valid,
    output ms2ws_bus,
    input  ws_allowin
  );

  modport slave (
    input  ms2ws_valid,
    input  ms2ws_bus,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: commits to the RF/CSR file, raises syscall/ertn flush.
// Ports: clk, reset, ms2ws (handshake+bus), rf_*, csr_*, wb_ex/ertn, trace.
module wb_stage #(
  parameter int          EXCEPT_LEN    = 82,
  parameter int          MS2WS_BUS_LEN = 70 + EXCEPT_LEN,
  parameter logic [5:0]  ECODE_SYS     = 6'h0B
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   ms2ws,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [37:0] wb_forward_zip,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic [63:0] retire_cnt,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int E = EXCEPT_LEN;

  logic                     ws_valid;
  logic                     ws_ready_go;
  logic                     flush;
  logic                     accept;
  logic [MS2WS_BUS_LEN-1:0] ws_bus;

  logic [31:0] pc;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] final_result;
  logic        sys_bit;
  logic        ertn_bit;
  logic        csr_re_bit;
  logic        csr_we_bit;

  assign pc           = ws_bus[E+69:E+38];
  assign gr_we        = ws_bus[E+37];
  assign dest         = ws_bus[E+36:E+32];
  assign final_result = ws_bus[E+31:E];
  assign csr_num      = ws_bus[81:68];
  assign csr_wmask    = ws_bus[67:36];
  assign csr_wvalue   = ws_bus[35:4];
  assign sys_bit      = ws_bus[3];
  assign ertn_bit     = ws_bus[2];
  assign csr_re_bit   = ws_bus[1];
  assign csr_we_bit   = ws_bus[0];

  assign ws_ready_go      = 1'b1;
  assign ms2ws.ws_allowin = ~ws_valid | ws_ready_go;
  assign accept           = ms2ws.ms2ws_valid & ms2ws.ws_allowin;

  assign wb_ex      = ws_valid & sys_bit;
  assign wb_ecode   = wb_ex ? ECODE_SYS : 6'd0;
  assign ertn_flush = ws_valid & ertn_bit & ~sys_bit;
  assign wb_pc      = ws_valid ? pc : 32'd0;
  assign flush      = wb_ex | ertn_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      ws_bus   <= '0;
    end else if (flush) begin
      // the offered instruction is younger than the flushing one
      ws_valid <= 1'b0;
    end else begin
      ws_valid <= accept;
      if (accept) ws_bus <= ms2ws.ms2ws_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      retire_cnt <= 64'd0;
    else if (ws_valid & ~wb_ex)
      retire_cnt <= retire_cnt + 64'd1;
  end

  // csr_rvalue is the pre-write value, giving csrxchg old-value semantics
  assign rf_we    = ws_valid & gr_we & ~wb_ex;
  assign rf_waddr = dest;
  assign rf_wdata = csr_re_bit ? csr_rvalue : final_result;
  assign csr_we   = ws_valid & csr_we_bit & ~wb_ex;

  assign wb_forward_zip = {rf_we, rf_waddr, rf_wdata};

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
// Drives the ms2ws interface and checks commit outputs after each edge.
module tb_wb_stage;

  localparam int BL = 152;

  logic        clk;
  logic        reset;
  logic [31:0] csr_rvalue;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [37:0] wb_forward_zip;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic [63:0] retire_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  wb_stage_if #(.MS2WS_BUS_LEN(BL)) ms2ws ();

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms2ws             (ms2ws),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .wb_forward_zip    (wb_forward_zip),
    .csr_num           (csr_num),
    .csr_rvalue        (csr_rvalue),
    .csr_we            (csr_we),
    .csr_wmask         (csr_wmask),
    .csr_wvalue        (csr_wvalue),
    .wb_ex             (wb_ex),
    .wb_ecode          (wb_ecode),
    .wb_pc             (wb_pc),
    .ertn_flush        (ertn_flush),
    .retire_cnt        (retire_cnt),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BL-1:0] mk(
    input logic [31:0] pc,
    input logic        gwe,
    input logic [4:0]  dst,
    input logic [31:0] res,
    input logic [13:0] num,
    input logic [31:0] msk,
    input logic [31:0] wv,
    input logic        sys,
    input logic        ert,
    input logic        cre,
    input logic        cwe
  );
    return {pc, gwe, dst, res, num, msk, wv, sys, ert, cre, cwe};
  endfunction

  function automatic logic [BL-1:0] alu(
    input logic [31:0] pc,
    input logic [4:0]  dst,
    input logic [31:0] res
  );
    return mk(pc, 1'b1, dst, res, 14'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    csr_rvalue = 32'd0;
    ms2ws.ms2ws_valid = 1'b1;
    ms2ws.ms2ws_bus = alu(32'h1c00_0f00, 5'd3, 32'h5555_aaaa);
    tick();
    tick();
    chk("rst_allowin", 64'(ms2ws.ws_allowin), 64'd1);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_retire", retire_cnt, 64'd0);
    chk("rst_wb_ex", 64'(wb_ex), 64'd0);
    chk("rst_dbg_pc", 64'(debug_wb_pc), 64'd0);
    chk("rst_wb_pc", 64'(wb_pc), 64'd0);
    reset = 1'b0;
    ms2ws.ms2ws_valid = 1'b0;
    tick();
    chk("idle_rf_we", 64'(rf_we), 64'd0);
    chk("idle_retire", retire_cnt, 64'd0);

    ms2ws.ms2ws_valid = 1'b1;
    ms2ws.ms2ws_bus = alu(32'h1c00_0000, 5'd5, 32'h1234_5678);
    tick();
    chk("a1_rf_we", 64'(rf_we), 64'd1);
    chk("a1_waddr", 64'(rf_waddr), 64'd5);
    chk("a1_wdata", 64'(rf_wdata), 64'h1234_5678);
    chk("a1_dbg_pc", 64'(debug_wb_pc), 64'h1c00_0000);
    chk("a1_dbg_we", 64'(debug_wb_rf_we), 64'hf);
    chk("a1_fwd", 64'(wb_forward_zip), {26'd0, 1'b1, 5'd5, 32'h1234_5678});
    chk("a1_retire", retire_cnt, 64'd0);
    ms2ws.ms2ws_bus = alu(32'h1c00_0004, 5'd6, 32'hdead_beef);
    tick();
    chk("a2_rf_we", 64'(rf_we), 64'd1);
    chk("a2_wnum", 64'(debug_wb_rf_wnum), 64'd6);
    chk("a2_wdata", 64'(debug_wb_rf_wdata), 64'hdead_beef);
    chk("a2_dbg_pc", 64'(debug_wb_pc), 64'h1c00_0004);
    chk("a2_retire", retire_cnt, 64'd1);
    ms2ws.ms2ws_valid = 1'b0;
    tick();
    chk("a3_rf_we", 64'(rf_we), 64'd0);
    chk("a3_retire", retire_cnt, 64'd2);

    ms2ws.ms2ws_valid = 1'b1;
    csr_rvalue = 32'h1111_2222;
    ms2ws.ms2ws_bus = mk(32'h1c00_0008, 1'b1, 5'd4, 32'h0, 14'h30,
                         32'h0000_ffff, 32'haaaa_5555,
                         1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("cx_csr_we", 64'(csr_we), 64'd1);
    chk("cx_num", 64'(csr_num), 64'h30);
    chk("cx_mask", 64'(csr_wmask), 64'h0000_ffff);
    chk("cx_wval", 64'(csr_wvalue), 64'haaaa_5555);
    chk("cx_wdata", 64'(rf_wdata), 64'h1111_2222);
    chk("cx_rf_we", 64'(rf_we), 64'd1);

    ms2ws.ms2ws_bus = mk(32'h1c00_0010, 1'b1, 5'd7, 32'h77, 14'h0,
                         32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("sc_wb_ex", 64'(wb_ex), 64'd1);
    chk("sc_ecode", 64'(wb_ecode), 64'h0b);
    chk("sc_wb_pc", 64'(wb_pc), 64'h1c00_0010);
    chk("sc_rf_we", 64'(rf_we), 64'd0);
    chk("sc_csr_we", 64'(csr_we), 64'd0);
    chk("sc_ertn", 64'(ertn_flush), 64'd0);
    chk("sc_retire", retire_cnt, 64'd3);
    ms2ws.ms2ws_bus = alu(32'h1c00_0014, 5'd8, 32'h88);
    tick();
    chk("sc2_wb_ex", 64'(wb_ex), 64'd0);
    chk("sc2_ecode", 64'(wb_ecode), 64'd0);
    chk("sc2_rf_we", 64'(rf_we), 64'd0);
    chk("sc2_wb_pc", 64'(wb_pc), 64'd0);
    chk("sc2_retire", retire_cnt, 64'd3);

    ms2ws.ms2ws_bus = mk(32'h1c00_0020, 1'b0, 5'd0, 32'h0, 14'h0,
                         32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("er_flush", 64'(ertn_flush), 64'd1);
    chk("er_wb_ex", 64'(wb_ex), 64'd0);
    chk("er_retire", retire_cnt, 64'd3);
    ms2ws.ms2ws_bus = alu(32'h1c00_0024, 5'd9, 32'h99);
    tick();
    chk("er2_flush", 64'(ertn_flush), 64'd0);
    chk("er2_rf_we", 64'(rf_we), 64'd0);
    chk("er2_retire", retire_cnt, 64'd4);

    ms2ws.ms2ws_bus = alu(32'h1c00_0030, 5'd10, 32'ha);
    tick();
    chk("b1_rf_we", 64'(rf_we), 64'd1);
    chk("b1_waddr", 64'(rf_waddr), 64'd10);
    ms2ws.ms2ws_valid = 1'b0;
    tick();
    chk("b2_rf_we", 64'(rf_we), 64'd0);
    chk("b2_retire", retire_cnt, 64'd5);
    tick();
    chk("b3_rf_we", 64'(rf_we), 64'd0);
    chk("b3_retire", retire_cnt, 64'd5);
    ms2ws.ms2ws_valid = 1'b1;
    ms2ws.ms2ws_bus = alu(32'h1c00_0034, 5'd11, 32'hb);
    tick();
    chk("b4_rf_we", 64'(rf_we), 64'd1);
    chk("b4_waddr", 64'(rf_waddr), 64'd11);
    ms2ws.ms2ws_valid = 1'b0;
    tick();
    chk("b5_rf_we", 64'(rf_we), 64'd0);
    chk("b5_retire", retire_cnt, 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Fifth and final pipeline stage. Consumes the memory stage's ms2ws_bus and valid handshake.
- Writes the architectural register file and forwards its write to the decode stage.
- Issues CSR write requests and selects CSR read data for csrrd/csrxchg.
- Raises the exception and ertn flush to all earlier stages. Drives the debug trace and a retired-instruction counter.

Parameters:
- EXCEPT_LEN, 82, width of except_zip. Layout MSB to LSB: {csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0], syscall, ertn, csr_re, csr_we}. Bits [3]/[2]/[1]/[0] are syscall/ertn/csr_re/csr_we.
- MS2WS_BUS_LEN, 70+EXCEPT_LEN (=152), width of ms2ws_bus. Layout MSB to LSB: {pc[31:0], gr_we, dest[4:0], final_result[31:0], except_zip}.
- ECODE_SYS, 6'h0B, exception code reported for syscall.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms2ws_valid  in  1  memory stage holds a valid instruction
- ws_allowin  out  1  WB can accept an instruction this cycle
- ms2ws_bus  in  MS2WS_BUS_LEN  instruction payload from memory stage
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- wb_forward_zip  out  38  {rf_we, rf_waddr, rf_wdata} to the decode bypass
- csr_num  out  14  CSR index (read and write)
- csr_rvalue  in  32  CSR read data for csr_num (combinational from CSR file)
- csr_we  out  1  CSR write strobe
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write value
- wb_ex  out  1  exception commit / flush
- wb_ecode  out  6  exception code, valid when wb_ex
- wb_pc  out  32  pc of the WB instruction (ERA source)
- ertn_flush  out  1  ertn commit / flush
- retire_cnt  out  64  count of committed instructions
- debug_wb_pc  out  32  trace pc
- debug_wb_rf_we  out  4  trace write enable, replicated
- debug_wb_rf_wnum  out  5  trace write register
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Reset (synchronous, active-high): ws_valid=0, all latched bus fields=0, retire_cnt=0. After reset all outputs are 0 except ws_allowin=1.
- Handshake: ws_ready_go=1. ws_allowin = ~ws_valid | ws_ready_go, so it is always 1.
- Latch: on every edge where ms2ws_valid & ws_allowin, capture ms2ws_bus. ws_valid loads the accept condition.
- Flush: flush = wb_ex | ertn_flush.
  - If flush is high at an edge, ws_valid <= 0. Any concurrently offered ms2ws instruction is dropped, because it is younger.
  - Reset has priority over flush, and flush has priority over accept.
- Exceptions:
  - wb_ex = ws_valid & syscall. wb_ecode = ECODE_SYS when wb_ex, else 0.
  - ertn_flush = ws_valid & ertn & ~syscall.
  - Each of these is a single-cycle pulse per instruction, guaranteed by the flush clearing ws_valid.
  - wb_pc = latched pc, driven whenever ws_valid, else 0.
- Register write:
  - rf_we = ws_valid & gr_we & ~wb_ex.
  - rf_waddr = dest.
  - rf_wdata = csr_re ? csr_rvalue : final_result.
  - A write to r0 is passed through unchanged; the register file ignores it.
- CSR:
  - csr_num/csr_wmask/csr_wvalue are taken directly from the latched fields.
  - csr_we = ws_valid & csr_we_bit & ~wb_ex.
  - The CSR read is combinational in the same cycle as the write. The read value reflects pre-write state, which gives csrxchg old-value semantics.
- Forwarding: wb_forward_zip = {rf_we, rf_waddr, rf_wdata}, combinational, same cycle.
- Retire counter: increments by 1 on each edge where ws_valid & ~wb_ex, and wraps modulo 2^64. ertn counts as retired; a syscall does not.
- Trace: debug_wb_pc = latched pc; debug_wb_rf_we = {4{rf_we}}; wnum/wdata mirror rf_waddr/rf_wdata.
- Latency: one cycle from memory-stage accept to commit. Back-to-back instructions commit every cycle.

Test Plan:
- Reset held 2 cycles, with ms2ws_valid=1 driven during reset -> after release ws_valid=0, rf_we=0, retire_cnt=0, ws_allowin=1.
- Back-to-back ALU ops (pc 0x1c000000, dest 5, result 0x12345678; then pc 0x1c000004, dest 6, result 0xdeadbeef) -> rf_we=1 on consecutive cycles with the matching waddr/wdata and trace values; retire_cnt=2.
- csrxchg: csr_num=0x30, csr_re=1, csr_we=1, mask 0x0000ffff, wvalue 0xaaaa5555, csr_rvalue=0x11112222 -> csr_we=1 with the same mask/value, rf_wdata=0x11112222, rf_we=1.
- syscall at pc 0x1c000010 with gr_we=1, and ms2ws_valid=1 in the same cycle -> wb_ex=1 and wb_ecode=0x0B for exactly 1 cycle, wb_pc=0x1c000010, rf_we=0, csr_we=0; the offered instruction is not latched (ws_valid=0 next cycle); retire_cnt unchanged.
- ertn -> ertn_flush=1 for 1 cycle, wb_ex=0, retire_cnt+1; next-cycle ws_valid=0 even with ms2ws_valid=1.
- Bubble gaps (ms2ws_valid toggling 1,0,0,1) -> rf_we only in valid cycles; retire_cnt counts 2.
